// File: rtl/ss_pkg.sv
// Shared types for the SS statistics datapath.
// Feed FSM state encoding is common to all SS-path sequencers.
package ss_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        FEED      = 3'd2,
        FLUSH     = 3'd3,
        WAIT_DONE = 3'd4
    } ss_feed_state_t;

endpackage

// File: rtl/ss_sample_buf.sv
// Sample buffer for ss_sum_feeder: fills in order from slot 0,
// read back through an externally driven read pointer.
module ss_sample_buf
    import ss_pkg::*;
#(
    parameter int SIZE_DATA  = 8,
    parameter int NUM_SAMPLE = 8,
    parameter int CW         = $clog2(NUM_SAMPLE + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 wr_en_i,
    input  logic [SIZE_DATA-1:0] wr_data_i,
    input  logic                 clr_i,
    input  logic [CW-1:0]        rd_ptr_i,
    output logic [SIZE_DATA-1:0] rd_data_o,
    output logic [CW-1:0]        count_o,
    output logic                 full_o
);

    logic [SIZE_DATA-1:0] mem_q [NUM_SAMPLE];
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 full;
    logic                 wr_ok;

    assign full  = (count_q == CW'(NUM_SAMPLE));
    assign wr_ok = wr_en_i && !full && !clr_i;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (wr_ok)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Contents need no reset: count gates every read that matters.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_SAMPLE; i++) begin
            if (wr_ok && count_q == CW'(i))
                mem_q[i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_SAMPLE; i++) begin
            if (rd_ptr_i == CW'(i))
                rd_data_o = mem_q[i];
        end
    end

    assign count_o = count_q;
    assign full_o  = full;

endmodule

// File: rtl/ss_sum_feeder.sv
// Initiator side of SS_cal_sum: streams buffered samples into the
// summing engine, then captures its sum or aborts on timeout.
module ss_sum_feeder
    import ss_pkg::*;
#(
    parameter int SIZE_DATA  = 8,
    parameter int NUM_SAMPLE = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [SIZE_DATA-1:0] i_wr_data,
    output logic                 o_full,
    input  logic                 i_start,
    output logic                 o_start_cal_sum,
    output logic                 o_en_cal_sum,
    output logic                 o_en_out_sum,
    output logic [SIZE_DATA-1:0] o_data,
    input  logic                 i_en_next_value,
    input  logic [SIZE_DATA:0]   i_sum,
    input  logic                 i_done,
    output logic [SIZE_DATA:0]   o_result,
    output logic                 o_result_valid,
    output logic                 o_busy,
    output logic                 o_error
);

    localparam int CW = $clog2(NUM_SAMPLE + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    ss_feed_state_t       state_q, state_d;
    logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        n_q, n_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [SIZE_DATA:0]   result_q, result_d;
    logic                 valid_q, valid_d;

    logic                 buf_wr;
    logic                 buf_clr;
    logic [SIZE_DATA-1:0] rd_data;
    logic [CW-1:0]        count;
    logic                 data_sel;

    assign buf_wr = i_wr_en && (state_q == IDLE) && !i_start;

    ss_sample_buf #(
        .SIZE_DATA  (SIZE_DATA),
        .NUM_SAMPLE (NUM_SAMPLE),
        .CW         (CW)
    ) u_buf (
        .clk_i     (i_clk),
        .rst_n_i   (i_rst_n),
        .wr_en_i   (buf_wr),
        .wr_data_i (i_wr_data),
        .clr_i     (buf_clr),
        .rd_ptr_i  (rd_ptr_q),
        .rd_data_o (rd_data),
        .count_o   (count),
        .full_o    (o_full)
    );

    always_comb begin
        state_d         = state_q;
        rd_ptr_d        = rd_ptr_q;
        n_d             = n_q;
        timer_d         = timer_q;
        result_d        = result_q;
        valid_d         = 1'b0;
        buf_clr         = 1'b0;
        data_sel        = 1'b0;
        o_start_cal_sum = 1'b0;
        o_en_cal_sum    = 1'b0;
        o_en_out_sum    = 1'b0;
        o_error         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start && count != '0) begin
                    n_d      = count;
                    rd_ptr_d = '0;
                    state_d  = START;
                end
            end
            START: begin
                o_start_cal_sum = 1'b1;
                data_sel        = 1'b1;
                rd_ptr_d        = '0;
                state_d         = FEED;
            end
            FEED: begin
                o_en_cal_sum = 1'b1;
                data_sel     = 1'b1;
                if (i_en_next_value) begin
                    if (rd_ptr_q == n_q - CW'(1))
                        state_d = FLUSH;
                    else
                        rd_ptr_d = rd_ptr_q + CW'(1);
                end
            end
            FLUSH: begin
                o_en_out_sum = 1'b1;
                timer_d      = '0;
                state_d      = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_done) begin
                    result_d = i_sum;
                    valid_d  = 1'b1;
                    buf_clr  = 1'b1;
                    state_d  = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    o_error = 1'b1;
                    buf_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            n_q      <= '0;
            timer_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            n_q      <= n_d;
            timer_q  <= timer_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // Engine input is quiet outside the streaming phase.
    assign o_data         = data_sel ? rd_data : '0;
    assign o_result       = result_q;
    assign o_result_valid = valid_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ss_sum_feeder.sv
// Directed bench for ss_sum_feeder with a behavioural SS_cal_sum responder.
module tb_ss_sum_feeder;

    localparam int SD = 8;
    localparam int NS = 8;
    localparam int TO = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_wr_en;
    logic [SD-1:0] i_wr_data;
    logic          o_full;
    logic          i_start;
    logic          o_start_cal_sum;
    logic          o_en_cal_sum;
    logic          o_en_out_sum;
    logic [SD-1:0] o_data;
    logic          i_en_next_value;
    logic [SD:0]   i_sum;
    logic          i_done;
    logic [SD:0]   o_result;
    logic          o_result_valid;
    logic          o_busy;
    logic          o_error;

    always #5 i_clk = ~i_clk;

    ss_sum_feeder #(
        .SIZE_DATA  (SD),
        .NUM_SAMPLE (NS),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_wr_en         (i_wr_en),
        .i_wr_data       (i_wr_data),
        .o_full          (o_full),
        .i_start         (i_start),
        .o_start_cal_sum (o_start_cal_sum),
        .o_en_cal_sum    (o_en_cal_sum),
        .o_en_out_sum    (o_en_out_sum),
        .o_data          (o_data),
        .i_en_next_value (i_en_next_value),
        .i_sum           (i_sum),
        .i_done          (i_done),
        .o_result        (o_result),
        .o_result_valid  (o_result_valid),
        .o_busy          (o_busy),
        .o_error         (o_error)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [SD-1:0] wvals [16];
    int r_starts, r_beats, r_enouts, r_valids, r_errs;
    int r_enout_cyc, r_err_cyc, r_cycles;

    task automatic write_samples(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_wr_en   = 1'b1;
            i_wr_data = wvals[i];
        end
        @(posedge i_clk); #1;
        i_wr_en = 1'b0;
    endtask

    // One run: start in cycle 0, engine model consumes with random gaps.
    task automatic run(input bit wr_start, input logic [SD-1:0] wr_d,
                       input int maxgap, input bit give_done);
        int k;
        int gap;
        int done_at;
        bit hold_v;
        logic [SD-1:0] hold_d;
        logic [SD:0] esum;
        r_starts = 0; r_beats = 0; r_enouts = 0; r_valids = 0; r_errs = 0;
        r_enout_cyc = -1; r_err_cyc = -1;
        esum = '0; hold_v = 1'b0; hold_d = '0; done_at = -1;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        k = 0;
        while (k < 200) begin
            @(posedge i_clk); #1;
            i_start = (k == 0);
            i_wr_en = (k == 0) && wr_start;
            i_wr_data = wr_d;
            i_en_next_value = 1'b0;
            i_done = 1'b0;
            if (o_en_cal_sum) begin
                if (hold_v) begin
                    vectors++;
                    if (o_data !== hold_d) begin
                        miscompares++;
                        $display("FAIL data_stable cyc=%0d got=%0d want=%0d", k, o_data, hold_d);
                    end
                end
                if (gap > 0) begin
                    gap--;
                    hold_v = 1'b1;
                    hold_d = o_data;
                end else begin
                    i_en_next_value = 1'b1;
                    hold_v = 1'b0;
                    vectors++;
                    if (r_beats >= 16 || o_data !== wvals[r_beats]) begin
                        miscompares++;
                        $display("FAIL data_order beat=%0d got=%0d", r_beats, o_data);
                    end
                    esum = esum + {1'b0, o_data};
                    r_beats++;
                    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                end
            end
            if (give_done && done_at == k) begin
                i_done = 1'b1;
                i_sum  = esum;
            end
            #1;
            if (o_start_cal_sum) r_starts++;
            if (o_en_out_sum) begin
                r_enouts++;
                r_enout_cyc = k;
                done_at = k + 2;
            end
            if (o_result_valid) r_valids++;
            if (o_error) begin
                r_errs++;
                r_err_cyc = k;
            end
            if (k > 0 && !o_busy) break;
            k++;
        end
        r_cycles = k;
        i_start = 1'b0; i_wr_en = 1'b0;
        i_en_next_value = 1'b0; i_done = 1'b0;
        if (k >= 200) begin
            miscompares++;
            $display("FAIL run_budget busy never dropped");
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        vectors++;
        if ({o_full, o_start_cal_sum, o_en_cal_sum, o_en_out_sum, o_data,
             o_result_valid, o_busy, o_error} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl got busy=%b full=%b data=%0d", o_busy, o_full, o_data);
        end
        vectors++;
        if (o_result !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_result got=%0d want=0", o_result);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        wvals[0] = 8'd10; wvals[1] = 8'd20; wvals[2] = 8'd30; wvals[3] = 8'd40;
        write_samples(4);
        run(1'b0, '0, 0, 1'b1);
        vectors++;
        if (r_starts != 1 || r_beats != 4 || r_enouts != 1 || r_valids != 1) begin
            miscompares++;
            $display("FAIL basic_strobes got st=%0d bt=%0d eo=%0d v=%0d want 1 4 1 1",
                     r_starts, r_beats, r_enouts, r_valids);
        end
        vectors++;
        if (r_enout_cyc != 6) begin
            miscompares++;
            $display("FAIL basic_latency got=%0d want=6", r_enout_cyc);
        end
        vectors++;
        if (o_result !== 9'd100) begin
            miscompares++;
            $display("FAIL basic_result got=%0d want=100", o_result);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) wvals[i] = 8'd255;
        wvals[8] = 8'd1;
        write_samples(9);
        vectors++;
        if (o_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_flag got=%b want=1", o_full);
        end
        run(1'b0, '0, 0, 1'b1);
        vectors++;
        if (r_beats != 8) begin
            miscompares++;
            $display("FAIL full_beats got=%0d want=8", r_beats);
        end
        vectors++;
        if (o_result !== 9'd504) begin
            miscompares++;
            $display("FAIL full_result got=%0d want=504", o_result);
        end
    endtask

    task automatic test_start_write();
        wvals[0] = 8'd5; wvals[1] = 8'd6;
        write_samples(2);
        run(1'b1, 8'd99, 0, 1'b1);
        vectors++;
        if (r_beats != 2 || o_result !== 9'd11) begin
            miscompares++;
            $display("FAIL start_write got beats=%0d res=%0d want 2 11", r_beats, o_result);
        end
    endtask

    task automatic test_gaps();
        logic [SD:0] exp;
        wvals[0] = 8'd3;   wvals[1] = 8'd250; wvals[2] = 8'd17;
        wvals[3] = 8'd128; wvals[4] = 8'd64;  wvals[5] = 8'd99;
        wvals[6] = 8'd200;
        exp = '0;
        for (int i = 0; i < 7; i++) exp = exp + {1'b0, wvals[i]};
        write_samples(7);
        run(1'b0, '0, 3, 1'b1);
        vectors++;
        if (r_beats != 7 || r_valids != 1 || o_result !== exp) begin
            miscompares++;
            $display("FAIL gaps_result got beats=%0d res=%0d want 7 %0d", r_beats, o_result, exp);
        end
    endtask

    task automatic test_timeout();
        logic [SD:0] prev;
        prev = o_result;
        wvals[0] = 8'd1; wvals[1] = 8'd2;
        write_samples(2);
        run(1'b0, '0, 0, 1'b0);
        vectors++;
        if (r_errs != 1 || r_err_cyc - r_enout_cyc != 16 || r_valids != 0) begin
            miscompares++;
            $display("FAIL timeout_err got errs=%0d dist=%0d v=%0d want 1 16 0",
                     r_errs, r_err_cyc - r_enout_cyc, r_valids);
        end
        vectors++;
        if (o_result !== prev || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_hold got res=%0d busy=%b want %0d 0", o_result, o_busy, prev);
        end
    endtask

    task automatic test_empty_start();
        run(1'b0, '0, 0, 1'b1);
        vectors++;
        if (r_starts != 0 || r_enouts != 0 || r_cycles != 1) begin
            miscompares++;
            $display("FAIL empty_start got st=%0d eo=%0d cyc=%0d want 0 0 1",
                     r_starts, r_enouts, r_cycles);
        end
    endtask

    task automatic test_midreset();
        wvals[0] = 8'd10; wvals[1] = 8'd20; wvals[2] = 8'd30;
        write_samples(3);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        vectors++;
        if (o_en_cal_sum !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_feed got en_cal=%b want=1", o_en_cal_sum);
        end
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        vectors++;
        if ({o_full, o_start_cal_sum, o_en_cal_sum, o_en_out_sum, o_data,
             o_result, o_result_valid, o_busy, o_error} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outs got busy=%b en_cal=%b data=%0d res=%0d",
                     o_busy, o_en_cal_sum, o_data, o_result);
        end
        wvals[0] = 8'd1; wvals[1] = 8'd2;
        write_samples(2);
        run(1'b0, '0, 1, 1'b1);
        vectors++;
        if (r_beats != 2 || o_result !== 9'd3) begin
            miscompares++;
            $display("FAIL midreset_rerun got beats=%0d res=%0d want 2 3", r_beats, o_result);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_start = 1'b0;
        i_en_next_value = 1'b0; i_sum = '0; i_done = 1'b0;
        for (int i = 0; i < 16; i++) wvals[i] = '0;
        test_reset();
        test_basic();
        test_full();
        test_start_write();
        test_gaps();
        test_timeout();
        test_empty_start();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
